// File: rtl/ar_arbiter.sv
// Round-robin arbiter sharing the address register (AR) between NREQ requesters,
// with sequenced AR clears. Define AR_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module ar_arbiter #(
  parameter int N       = 17,
  parameter int NREQ    = 4,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] addr_in,
  input  logic              ar_clr,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              ar_write_en,
  output logic              ar_clr_en,
  output logic [N-1:0]      ar_datain,
  output logic              mem_rd_en,
  output logic              busy
);

  localparam int              PW   = $clog2(NREQ);
  localparam logic [3:0]      LAST = 4'(MEM_LAT - 1);
  localparam logic [NREQ-1:0] ONE  = NREQ'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   win_q, win_d;
  logic [3:0]      cnt_q;
  logic            pend_q;
  logic [N-1:0]    data_q;
  logic [N-1:0]    addr_arr [NREQ];

  always_comb begin
    for (int k = 0; k < NREQ; k++) addr_arr[k] = addr_in[k*N +: N];
  end

`ifdef AR_ARB_FIXED_PRIO_EN
  always_comb begin
    win_d = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) win_d = PW'(i);
    end
  end
`else
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] rr_sel;
  logic          rr_found;
  int            rr_idx;

  // First requesting index at or above ptr, wrapping past NREQ-1.
  always_comb begin
    win_d    = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    rr_sel   = '0;
    for (int i = 0; i < NREQ; i++) begin
      rr_idx = int'(ptr_q) + i;
      if (rr_idx >= NREQ) rr_idx = rr_idx - NREQ;
      rr_sel = rr_idx[PW-1:0];
      if (!rr_found && req[rr_sel]) begin
        win_d    = rr_sel;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (state_q == S_DONE) begin
      ptr_q <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q || ar_clr) state_d = S_CLEAR;
        else if (|req)        state_d = S_LOAD;
      end
      S_CLEAR:  state_d = S_IDLE;
      S_LOAD:   state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == LAST) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && state_d == S_LOAD) begin
        win_q  <= win_d;
        data_q <= addr_arr[win_d];
      end
      cnt_q <= (state_q == S_ACCESS) ? cnt_q + 4'd1 : 4'd0;
      // Clears arriving while busy collapse into a single deferred clear.
      if (state_q == S_IDLE && state_d == S_CLEAR) pend_q <= 1'b0;
      else if (ar_clr && state_q != S_IDLE)        pend_q <= 1'b1;
    end
  end

  assign gnt         = (state_q == S_LOAD || state_q == S_ACCESS || state_q == S_DONE)
                       ? (ONE << win_q) : '0;
  assign ack         = (state_q == S_DONE) ? (ONE << win_q) : '0;
  assign ar_write_en = (state_q == S_LOAD);
  assign ar_clr_en   = (state_q == S_CLEAR);
  assign mem_rd_en   = (state_q == S_ACCESS);
  assign busy        = (state_q != S_IDLE);
  assign ar_datain   = data_q;

endmodule

// File: tb/tb_ar_arbiter.sv
// Bench for ar_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a transaction-timeline reference model.
module tb_ar_arbiter;

  localparam int N       = 17;
  localparam int NREQ    = 4;
  localparam int MEM_LAT = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*N-1:0] addr_in = '0;
  logic              ar_clr = 1'b0;
  logic [NREQ-1:0]   gnt, ack;
  logic              ar_write_en, ar_clr_en, mem_rd_en, busy;
  logic [N-1:0]      ar_datain;

  int tests = 0;
  int fails = 0;

  ar_arbiter #(.N(N), .NREQ(NREQ), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr_in(addr_in), .ar_clr(ar_clr),
    .gnt(gnt), .ack(ack), .ar_write_en(ar_write_en), .ar_clr_en(ar_clr_en),
    .ar_datain(ar_datain), .mem_rd_en(mem_rd_en), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req    = '0;
    ar_clr = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [63:0] pack_out();
    return {35'b0, gnt, ack, ar_write_en, ar_clr_en, mem_rd_en, busy, ar_datain};
  endfunction

  function automatic logic [63:0] mk(logic [3:0] g, logic [3:0] a, logic we, logic ce,
                                     logic rd, logic b, logic [N-1:0] d);
    return {35'b0, g, a, we, ce, rd, b, d};
  endfunction

  function automatic int pick(logic [NREQ-1:0] r, int p);
`ifdef AR_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`else
    for (int i = 0; i < NREQ; i++) if (r[(p + i) % NREQ]) return (p + i) % NREQ;
`endif
    return 0;
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NREQ-1:0] req;
    logic [N-1:0]    a0;
    logic            clr;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic            we, ce, rd, busy;
    logic [N-1:0]    data;
  } vec_t;

  vec_t vt [14];

  // ---------------- scoreboard ----------------
  logic [NREQ+N-1:0] exp_q [$];

  // ---------------- random-phase reference model ----------------
  logic [N-1:0]    addr_r [NREQ];
  int              m_start, m_clr_at, m_win, m_ptr;
  bit              m_pend;
  logic [N-1:0]    m_addr;

  initial begin
    vt[0]  = '{4'b0001, 17'h00ABC, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00000};
    vt[1]  = '{4'b0001, 17'h00ABC, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 17'h00ABC};
    vt[2]  = '{4'b0001, 17'h00ABC, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 17'h00ABC};
    vt[3]  = '{4'b0001, 17'h00ABC, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 17'h00ABC};
    vt[4]  = '{4'b0000, 17'h00ABC, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 17'h00ABC};
    vt[5]  = '{4'b0000, 17'h00ABC, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00ABC};
    vt[6]  = '{4'b0001, 17'h1F00F, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00ABC};
    vt[7]  = '{4'b0001, 17'h1F00F, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 17'h00ABC};
    vt[8]  = '{4'b0001, 17'h1F00F, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 17'h00ABC};
    vt[9]  = '{4'b0001, 17'h1F00F, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 17'h1F00F};
    vt[10] = '{4'b0001, 17'h1F00F, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 17'h1F00F};
    vt[11] = '{4'b0001, 17'h1F00F, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 17'h1F00F};
    vt[12] = '{4'b0000, 17'h1F00F, 1'b0, 4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 17'h1F00F};
    vt[13] = '{4'b0000, 17'h1F00F, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 17'h1F00F};

    // Single access, then clear and request in the same IDLE cycle.
    do_reset();
    for (int i = 0; i < 14; i++) begin
      req     = vt[i].req;
      addr_in = '0;
      addr_in[N-1:0] = vt[i].a0;
      ar_clr  = vt[i].clr;
      check($sformatf("vec%0d", i), pack_out(),
            mk(vt[i].gnt, vt[i].ack, vt[i].we, vt[i].ce, vt[i].rd, vt[i].busy, vt[i].data));
      @(negedge clk);
    end

    // Round robin with all requesters held high: ack every MEM_LAT+3 cycles.
    do_reset();
    for (int k = 0; k < NREQ; k++) addr_in[k*N +: N] = N'(17'h10000 + k);
    req = 4'b1111;
    for (int c = 0; c <= 25; c++) begin
      logic [3:0] ea;
      ea = '0;
`ifdef AR_ARB_FIXED_PRIO_EN
      if (c % 5 == 4) ea = 4'b0001;
`else
      if (c % 5 == 4) ea[(c / 5) % NREQ] = 1'b1;
`endif
      check($sformatf("rr_ack_c%0d", c), {60'b0, ack}, {60'b0, ea});
      @(negedge clk);
    end

    // Two clear pulses while busy collapse into one clear after the ack.
    do_reset();
    addr_in = '0;
    addr_in[N +: N] = 17'h12345;
    req = 4'b0010;
    for (int c = 0; c <= 9; c++) begin
      ar_clr = (c == 2 || c == 3);
      check($sformatf("clrbusy_c%0d", c), {58'b0, ack, ar_write_en, ar_clr_en},
            {58'b0, (c == 4) ? 4'b0010 : 4'b0000, (c == 1 || c == 8), (c == 6)});
      @(negedge clk);
    end
    ar_clr = 1'b0;

    // Reset during ACCESS of the second transaction; pointer must restart at 0.
    do_reset();
    for (int k = 0; k < NREQ; k++) addr_in[k*N +: N] = N'(17'h0A000 + k);
    req = 4'b1111;
    repeat (7) @(negedge clk);
    check("pre_rst_rd", {63'b0, mem_rd_en}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", pack_out(), 64'd0);
    req = 4'b0101;
    repeat (2) begin
      @(negedge clk);
      check("rst_hold_out", pack_out(), 64'd0);
    end
    rst_n = 1'b1;
    for (int c = 0; c <= 7; c++) begin
      if (c == 1) check("post_rst_gnt", {60'b0, gnt}, {60'b0, 4'b0001});
      if (c == 4) check("post_rst_ack", {60'b0, ack}, {60'b0, 4'b0001});
      if (c == 6) check("post_rst_gnt2", {60'b0, gnt}, {60'b0, 4'b0100});
      if (c == 4) req = 4'b0100;
      @(negedge clk);
    end
    req = '0;

    // Randomized traffic against the timeline model.
    do_reset();
    for (int k = 0; k < NREQ; k++) addr_r[k] = '0;
    m_start = -100; m_clr_at = -100; m_win = 0; m_ptr = 0; m_pend = 0; m_addr = '0;
    exp_q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] eg, ea;
      logic       ewe, ece, erd, eb, in_win, clr;
      logic [NREQ-1:0] nreq;
      in_win = (c >= m_start) && (c <= m_start + MEM_LAT + 1);
      eg = '0; ea = '0; ewe = 0; ece = 0; erd = 0; eb = 0;
      if (in_win) begin
        eg[m_win] = 1'b1;
        ewe = (c == m_start);
        erd = (c > m_start) && (c <= m_start + MEM_LAT);
        ea  = (c == m_start + MEM_LAT + 1) ? eg : 4'b0000;
        eb  = 1'b1;
      end else if (c == m_clr_at) begin
        ece = 1'b1;
        eb  = 1'b1;
      end
      check("rand_out", pack_out(), mk(eg, ea, ewe, ece, erd, eb, m_addr));
      if (ack != '0) begin
        if (exp_q.size() == 0) check("sb_empty", {60'b0, ack}, 64'd0);
        else check("sb_ack", {43'b0, gnt, ar_datain}, {43'b0, exp_q.pop_front()});
      end

      nreq = req;
      for (int k = 0; k < NREQ; k++) begin
        if (ea[k]) begin
          if ($urandom_range(0, 1) == 0) nreq[k] = 1'b0;
          else addr_r[k] = N'($urandom);
        end else if (!nreq[k] && $urandom_range(0, 3) == 0) begin
          nreq[k]   = 1'b1;
          addr_r[k] = N'($urandom);
        end
      end
      clr = ($urandom_range(0, 15) == 0);
      req = nreq;
      ar_clr = clr;
      for (int k = 0; k < NREQ; k++) addr_in[k*N +: N] = addr_r[k];

      if (!in_win && c != m_clr_at) begin
        if (m_pend || clr) begin
          m_clr_at = c + 1;
          m_pend   = 0;
        end else if (nreq != '0) begin
          logic [NREQ-1:0] oh;
          m_win   = pick(nreq, m_ptr);
          m_start = c + 1;
          m_addr  = addr_r[m_win];
          oh = '0;
          oh[m_win] = 1'b1;
          exp_q.push_back({oh, m_addr});
        end
      end else begin
        if (clr) m_pend = 1;
        if (in_win && c == m_start + MEM_LAT + 1) m_ptr = (m_win + 1) % NREQ;
      end
      @(negedge clk);
    end
    check("sb_backlog", 64'(exp_q.size() > 1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
